// File: rtl/datapath_seq_ctrl_if.sv
// datapath_seq_ctrl_if: host/datapath control bundle for the instruction sequencer
//   run, d_inst                   host -> sequencer (start request, instruction/immediate word)
//   mux_sel, en, en_a, en_g,      sequencer -> datapath (bus source, register/A/G enables,
//   alu_sel, en_inst              ALU op, IR load strobe)
//   busy, done                    sequencer -> host (status, one-cycle completion pulse)
//   illegal                       sequencer -> host, only with CTRL_ILLEGAL_FLAG_EN
interface datapath_seq_ctrl_if #(
  parameter int IW   = 16,
  parameter int NREG = 8,
  parameter int MUXW = 4
);
  logic            run;
  logic [IW-1:0]   d_inst;
  logic [MUXW-1:0] mux_sel;
  logic [NREG-1:0] en;
  logic            en_a;
  logic            en_g;
  logic [2:0]      alu_sel;
  logic            en_inst;
  logic            busy;
  logic            done;
`ifdef CTRL_ILLEGAL_FLAG_EN
  logic            illegal;
  modport master (output run, d_inst, input mux_sel, en, en_a, en_g, alu_sel, en_inst, busy, done, illegal);
  modport slave  (input run, d_inst, output mux_sel, en, en_a, en_g, alu_sel, en_inst, busy, done, illegal);
`else
  modport master (output run, d_inst, input mux_sel, en, en_a, en_g, alu_sel, en_inst, busy, done);
  modport slave  (input run, d_inst, output mux_sel, en, en_a, en_g, alu_sel, en_inst, busy, done);
`endif
endinterface

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: multi-cycle sequencer issuing MV/MVI/ALU control over 1-3 execute cycles
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (returns to IDLE, clears IR)
//   bus      datapath_seq_ctrl_if.slave: run/d_inst in; mux_sel, en, en_a, en_g, alu_sel,
//            en_inst, busy, done (and illegal) out
//   CTRL_ILLEGAL_FLAG_EN: when defined, bus.illegal pulses with done for op=11
module datapath_seq_ctrl #(
  parameter int IW   = 16,
  parameter int NREG = 8,
  parameter int MUXW = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  datapath_seq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [2:0]    rx, ry;
  logic [1:0]    op;
  logic [NREG-1:0] en_rx;
  assign rx    = ir_q[15:13];
  assign ry    = ir_q[12:10];
  assign op    = ir_q[9:8];
  assign en_rx = NREG'(1) << rx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    bus.mux_sel = '0;
    bus.en      = '0;
    bus.en_a    = 1'b0;
    bus.en_g    = 1'b0;
    bus.alu_sel = '0;
    bus.en_inst = 1'b0;
    bus.done    = 1'b0;
`ifdef CTRL_ILLEGAL_FLAG_EN
    bus.illegal = 1'b0;
`endif
    bus.busy    = state_q != IDLE;
    case (state_q)
      IDLE: begin
        // gated by reset_n so every output reads 0 while reset is held
        bus.en_inst = bus.run & reset_n;
        if (bus.run) begin
          ir_d    = bus.d_inst;
          state_d = T1;
        end
      end
      T1: begin
        state_d = op == 2'b10 ? T2 : IDLE;
        bus.done = op != 2'b10;
        bus.en   = op[1] ? '0 : en_rx;
        bus.en_a = op == 2'b10;
        bus.mux_sel = op == 2'b00 ? MUXW'(ry) : op == 2'b01 ? MUXW'(8) : op == 2'b10 ? MUXW'(rx) : '0;
`ifdef CTRL_ILLEGAL_FLAG_EN
        bus.illegal = op == 2'b11;
`endif
      end
      T2: begin
        bus.mux_sel = MUXW'(ry);
        bus.alu_sel = ir_q[4:2];
        bus.en_g    = 1'b1;
        state_d     = T3;
      end
      default: begin
        bus.mux_sel = MUXW'(9);
        bus.en      = en_rx;
        bus.done    = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl: directed self-checking bench for datapath_seq_ctrl
module tb_datapath_seq_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  datapath_seq_ctrl_if bus ();
  datapath_seq_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_o(input string tag, input logic [3:0] mux, input logic [7:0] en,
                       input logic ea, input logic eg, input logic [2:0] alu,
                       input logic ei, input logic b, input logic d, input logic il);
    logic [20:0] obs, exp;
    logic        obs_il;
`ifdef CTRL_ILLEGAL_FLAG_EN
    obs_il = bus.illegal;
`else
    obs_il = 1'b0;
    il     = 1'b0;
`endif
    #1;
    obs = {bus.mux_sel, bus.en, bus.en_a, bus.en_g, bus.alu_sel, bus.en_inst, bus.busy, bus.done, obs_il};
    exp = {mux, en, ea, eg, alu, ei, b, d, il};
    chk(tag, 32'(obs), 32'(exp));
  endtask
  initial begin
    reset_n = 1'b0;
    bus.run = 1'b0;
    bus.d_inst = '0;
    tick; tick;
    reset_n = 1'b1;
    chk_o("idle_after_reset", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // ALU R2,R2 alu=2
    bus.run = 1'b1; bus.d_inst = 16'h4A08;
    chk_o("alu_accept", 0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    tick; bus.run = 1'b0;
    chk_o("alu_t1", 2, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    tick;
    chk_o("alu_t2", 2, 8'h00, 0, 1, 2, 0, 1, 0, 0);
    tick;
    chk_o("alu_t3", 9, 8'h04, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk_o("alu_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // ALU R6,R3 alu=5
    bus.run = 1'b1; bus.d_inst = 16'hCE14;
    tick; bus.run = 1'b0;
    chk_o("alu2_t1", 6, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    tick;
    chk_o("alu2_t2", 3, 8'h00, 0, 1, 5, 0, 1, 0, 0);
    tick;
    chk_o("alu2_t3", 9, 8'h40, 0, 0, 0, 0, 1, 1, 0);
    tick;
    // reset in T2 with run held high
    bus.run = 1'b1; bus.d_inst = 16'h4A08;
    tick; tick;
    chk_o("pre_reset_t2", 2, 8'h00, 0, 1, 2, 0, 1, 0, 0);
    reset_n = 1'b0;
    chk_o("reset_outs", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_state", 32'(dut.state_q), 32'd0);
    chk("reset_ir", 32'(dut.ir_q), 32'd0);
    tick;
    chk_o("reset_hold", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    bus.run = 1'b0; reset_n = 1'b1;
    chk_o("reset_release", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // MV R1,R1
    bus.run = 1'b1; bus.d_inst = 16'h2400;
    tick; bus.run = 1'b0;
    chk_o("mv_t1", 1, 8'h02, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk_o("mv_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // MV R5,R2
    bus.run = 1'b1; bus.d_inst = 16'hA800;
    tick; bus.run = 1'b0;
    chk_o("mv2_t1", 2, 8'h20, 0, 0, 0, 0, 1, 1, 0);
    tick;
    // MVI R3 with immediate on d_inst during T1
    bus.run = 1'b1; bus.d_inst = 16'h6100;
    tick; bus.run = 1'b0; bus.d_inst = 16'h00A5;
    chk_o("mvi_t1", 8, 8'h08, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk_o("mvi_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // reserved op
    bus.run = 1'b1; bus.d_inst = 16'h0300;
    tick; bus.run = 1'b0;
    chk_o("nop_t1", 0, 8'h00, 0, 0, 0, 0, 1, 1, 1);
    tick;
    chk_o("nop_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back ALU then MV with run held and d_inst disturbed mid-flight
    bus.run = 1'b1; bus.d_inst = 16'h4A08;
    tick; bus.d_inst = 16'hFFFF;
    chk_o("b2b_c1_t1", 2, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    tick;
    chk_o("b2b_c2_t2", 2, 8'h00, 0, 1, 2, 0, 1, 0, 0);
    tick; bus.d_inst = 16'h2400;
    chk_o("b2b_c3_done", 9, 8'h04, 0, 0, 0, 0, 1, 1, 0);
    tick;
    chk_o("b2b_c4_accept", 0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    tick; bus.d_inst = 16'hFFFF;
    chk_o("b2b_c5_done", 1, 8'h02, 0, 0, 0, 0, 1, 1, 0);
    bus.run = 1'b0;
    tick;
    chk_o("b2b_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
